pwm_ramp_ctrl: RTL and testbench

APB-configured scheduler that drives the pulse-width inputs of NUM_CH servo/motor PWM generators.
- Software writes a target pulse width per channel.
- The block slews each channel's active pulse width toward its target by at most STEP counts per PWM period, so actuators never see step changes.
- Updates are frame-aligned: one shared adder visits the channels in turn, starting at the period boundary.
- Sits between the APB bus and the PWM generator instances.

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_ramp_ctrl_if.sv | 26 ++
 rtl/pwm_slew_step.sv | 46 ++++
 rtl/pwm_ramp_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, register map and FSM state type for the PWM ramp controller.
package pwm_pkg;

    // Default pulse-width limits and neutral position, in PCLK counts.
    localparam int WIDTH_MIN_DEF = 50000;
    localparam int WIDTH_MAX_DEF = 100000;
    localparam int WIDTH_RST_DEF = 75000;

    // Slew step loaded at reset.
    localparam logic [19:0] STEP_RST = 20'd500;

    // Register word indices (byte address bits [7:2]).
    localparam logic [5:0] REG_CTRL   = 6'd0;
    localparam logic [5:0] REG_STEP   = 6'd1;
    localparam logic [5:0] REG_STATUS = 6'd2;
    localparam logic [5:0] REG_TARGET = 6'd8;
    localparam logic [5:0] REG_ACTIVE = 6'd16;

    // Update scheduler states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    // Clamp an unsigned width into [lo, hi].
    function automatic logic [31:0] clamp_width(input logic [31:0] value,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// APB slave bus bundle for the PWM ramp controller.
//
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by an
// access cycle (PSEL=1, PENABLE=1). PREADY is tied high, so every access
// phase completes in one cycle; writes commit on the clock edge that ends
// the access phase, and PRDATA/PSLVERR are valid throughout that phase.
interface pwm_ramp_ctrl_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/pwm_slew_step.sv
// One slew step: moves active toward target by at most step, never past it,
// and keeps the result inside [WIDTH_MIN, WIDTH_MAX].
import pwm_pkg::*;

module pwm_slew_step #(
    parameter int WIDTH_MIN = WIDTH_MIN_DEF,
    parameter int WIDTH_MAX = WIDTH_MAX_DEF
) (
    input  logic [31:0] active,
    input  logic [31:0] target,
    input  logic [19:0] step,
    output logic [31:0] next_active
);

    localparam logic signed [32:0] MIN_S = 33'(WIDTH_MIN);
    localparam logic signed [32:0] MAX_S = 33'(WIDTH_MAX);

    logic signed [32:0] active_s;
    logic signed [32:0] target_s;
    logic signed [32:0] step_s;
    logic signed [32:0] diff;
    logic signed [32:0] mag;
    logic signed [32:0] cand;

    // Signed 33-bit difference so both directions compare without wrap.
    always_comb begin
        active_s = $signed({1'b0, active});
        target_s = $signed({1'b0, target});
        step_s   = $signed({13'b0, step});
        diff     = target_s - active_s;
        mag      = (diff < 0) ? -diff : diff;
        if (mag <= step_s)
            cand = target_s;
        else if (diff < 0)
            cand = active_s - step_s;
        else
            cand = active_s + step_s;
        if (cand < MIN_S)
            next_active = MIN_S[31:0];
        else if (cand > MAX_S)
            next_active = MAX_S[31:0];
        else
            next_active = cand[31:0];
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// APB-configured pulse-width scheduler: slews each channel's active width
// toward its target once per PWM frame using one shared slew step.
import pwm_pkg::*;

module pwm_ramp_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int PERIOD    = 1000000,
    parameter int WIDTH_MIN = WIDTH_MIN_DEF,
    parameter int WIDTH_MAX = WIDTH_MAX_DEF,
    parameter int WIDTH_RST = WIDTH_RST_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    pwm_ramp_ctrl_if.slave        apb,
    output logic [32*NUM_CH-1:0]  pulse_width,
    output logic                  frame_start,
    output logic                  busy,
    output state_e                dbg_state
);

    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [31:0]     CNT_LAST = 32'(PERIOD - 1);
    localparam logic [31:0]     RST_W    = 32'(WIDTH_RST);

    logic [31:0]     period_cnt;
    logic            enable_q;
    logic [19:0]     step_q;
    logic [31:0]     target_q [NUM_CH];
    logic [31:0]     active_q [NUM_CH];
    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_idx_q, ch_idx_d;
    logic            upd_en;
    logic [NUM_CH-1:0] mismatch;
    logic [31:0]     slew_next;
    logic [31:0]     status_word;
    logic [31:0]     rdata;

    // APB decode
    logic            access, wr_en, snap;
    logic [5:0]      widx;
    logic [CH_W-1:0] sel;
    logic            hit_ctrl, hit_step, hit_status, hit_target, hit_active;
    logic            wr_ok, rd_ok;
    logic            unused_addr_bits;

    assign access     = apb.PSEL & apb.PENABLE;
    assign widx       = apb.PADDR[7:2];
    assign sel        = widx[CH_W-1:0];
    assign hit_ctrl   = (widx == REG_CTRL);
    assign hit_step   = (widx == REG_STEP);
    assign hit_status = (widx == REG_STATUS);
    assign hit_target = (widx >= REG_TARGET) && (widx < REG_TARGET + 6'(NUM_CH));
    assign hit_active = (widx >= REG_ACTIVE) && (widx < REG_ACTIVE + 6'(NUM_CH));
    assign wr_ok      = hit_ctrl | hit_step | hit_target;
    assign rd_ok      = wr_ok | hit_status | hit_active;
    assign wr_en      = access & apb.PWRITE & wr_ok;
    assign snap       = wr_en & hit_ctrl & apb.PWDATA[1];
    assign unused_addr_bits = ^{apb.PADDR[31:8], apb.PADDR[1:0]};

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & (apb.PWRITE ? ~wr_ok : ~rd_ok);
    assign apb.PRDATA  = access ? rdata : 32'd0;

    // Frame counter; frame_start is registered off the terminal count.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            period_cnt  <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (period_cnt == CNT_LAST);
            period_cnt  <= (period_cnt == CNT_LAST) ? '0 : period_cnt + 32'd1;
        end
    end

    // Software-visible configuration: enable, step and clamped targets.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            enable_q <= 1'b0;
            step_q   <= STEP_RST;
            for (int c = 0; c < NUM_CH; c++) target_q[c] <= RST_W;
        end else if (wr_en) begin
            if (hit_ctrl) enable_q <= apb.PWDATA[0];
            if (hit_step) step_q <= (apb.PWDATA[19:0] == 20'd0) ? 20'd1 : apb.PWDATA[19:0];
            for (int c = 0; c < NUM_CH; c++)
                if (hit_target && sel == CH_W'(c))
                    target_q[c] <= clamp_width(apb.PWDATA, 32'(WIDTH_MIN), 32'(WIDTH_MAX));
        end
    end

    // Shared slew step for the channel currently addressed by the scheduler.
    pwm_slew_step #(
        .WIDTH_MIN (WIDTH_MIN),
        .WIDTH_MAX (WIDTH_MAX)
    ) u_slew (
        .active      (active_q[ch_idx_q]),
        .target      (target_q[ch_idx_q]),
        .step        (step_q),
        .next_active (slew_next)
    );

    // Active widths: SNAP copies every target, otherwise one channel per UPDATE cycle.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            for (int c = 0; c < NUM_CH; c++) active_q[c] <= RST_W;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (snap)
                    active_q[c] <= target_q[c];
                else if (upd_en && ch_idx_q == CH_W'(c))
                    active_q[c] <= slew_next;
            end
        end
    end

    // Scheduler state register.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
        end
    end

    // Scheduler next state: start a pass on an enabled, busy frame boundary.
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        upd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start && enable_q && busy) begin
                    state_d  = ST_UPDATE;
                    ch_idx_d = '0;
                end
            end
            ST_UPDATE: begin
                upd_en = 1'b1;
                if (ch_idx_q == CH_LAST) begin
                    state_d  = ST_IDLE;
                    ch_idx_d = '0;
                end else begin
                    ch_idx_d = ch_idx_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ch_idx_d = '0;
            end
        endcase
        if (snap) begin
            state_d  = ST_IDLE;
            ch_idx_d = '0;
            upd_en   = 1'b0;
        end
    end

    // Per-channel mismatch and status word.
    always_comb begin
        status_word = '0;
        for (int c = 0; c < NUM_CH; c++) mismatch[c] = (active_q[c] != target_q[c]);
        status_word[NUM_CH-1:0] = mismatch;
        status_word[31]         = (state_q != ST_IDLE);
    end

    // busy is the registered OR of the mismatch flags.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) busy <= 1'b0;
        else          busy <= |mismatch;
    end

    // Read data mux for the decoded word index.
    always_comb begin
        rdata = '0;
        if (hit_ctrl)        rdata = {31'b0, enable_q};
        else if (hit_step)   rdata = {12'b0, step_q};
        else if (hit_status) rdata = status_word;
        else if (hit_target) rdata = target_q[sel];
        else if (hit_active) rdata = active_q[sel];
    end

    assign dbg_state = state_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pw
        assign pulse_width[32*c +: 32] = active_q[c];
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed testbench for pwm_ramp_ctrl with a short PWM frame.
import pwm_pkg::*;

module tb_pwm_ramp_ctrl;

    localparam int NUM_CH = 4;
    localparam int PERIOD = 40;

    logic                 PCLK = 1'b0;
    logic                 PRESERN = 1'b0;
    logic [32*NUM_CH-1:0] pulse_width;
    logic                 frame_start;
    logic                 busy;
    state_e               dbg_state;

    int n_vec = 0;
    int n_err = 0;

    pwm_ramp_ctrl_if apb_if ();

    pwm_ramp_ctrl #(
        .NUM_CH (NUM_CH),
        .PERIOD (PERIOD)
    ) dut (
        .PCLK        (PCLK),
        .PRESERN     (PRESERN),
        .apb         (apb_if),
        .pulse_width (pulse_width),
        .frame_start (frame_start),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] pw(input int c);
        return pulse_width[32*c +: 32];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apb_idle();
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = '0;  apb_if.PWDATA = '0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(negedge PCLK);
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = addr; apb_if.PWDATA = data;
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        #1 err = apb_if.PSLVERR;
        @(negedge PCLK);
        apb_idle();
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge PCLK);
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0; apb_if.PADDR = addr;
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        #1 data = apb_if.PRDATA; err = apb_if.PSLVERR;
        @(negedge PCLK);
        apb_idle();
    endtask

    // Returns at the negedge where frame_start is seen high.
    task automatic wait_frame();
        bit ok = 1'b0;
        for (int i = 0; i < 3*PERIOD && !ok; i++) begin
            @(negedge PCLK);
            if (frame_start === 1'b1) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL wait_frame: frame_start not seen within %0d cycles", 3*PERIOD); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d; logic e;
        apb_idle();
        PRESERN = 1'b0;
        repeat (3) @(negedge PCLK);
        n_vec++; if (pulse_width !== {NUM_CH{32'd75000}}) begin n_err++; $display("FAIL reset_pw: got %h exp all 75000", pulse_width); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b exp 0", frame_start); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
        n_vec++; if (apb_if.PREADY !== 1'b1) begin n_err++; $display("FAIL pready: got %b exp 1", apb_if.PREADY); end
        n_vec++; if (apb_if.PRDATA !== 32'd0) begin n_err++; $display("FAIL idle_prdata: got %h exp 0", apb_if.PRDATA); end
        PRESERN = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            apb_read(32'h40 + 4*c, d, e);
            n_vec++; if (d !== 32'd75000 || e !== 1'b0) begin n_err++; $display("FAIL reset_active%0d: got %0d err %b exp 75000 err 0", c, d, e); end
        end
        apb_read(32'h04, d, e);
        n_vec++; if (d !== 32'd500) begin n_err++; $display("FAIL reset_step: got %0d exp 500", d); end
        apb_read(32'h00, d, e);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h exp 0", d); end
    endtask

    task automatic test_ramp();
        logic e;
        wait_frame();
        apb_write(32'h04, 32'd1000, e);
        apb_write(32'h20, 32'd80000, e);
        apb_write(32'h00, 32'h1, e);
        wait_frame();
        @(negedge PCLK);
        n_vec++; if (pw(0) !== 32'd75000) begin n_err++; $display("FAIL ramp_early: got %0d exp 75000", pw(0)); end
        n_vec++; if (dbg_state !== ST_UPDATE) begin n_err++; $display("FAIL ramp_state: got %0d exp UPDATE", dbg_state); end
        @(negedge PCLK);
        n_vec++; if (pw(0) !== 32'd76000) begin n_err++; $display("FAIL ramp_f1: got %0d exp 76000", pw(0)); end
        for (int c = 1; c < NUM_CH; c++) begin
            n_vec++; if (pw(c) !== 32'd75000) begin n_err++; $display("FAIL ramp_other%0d: got %0d exp 75000", c, pw(c)); end
        end
        for (int k = 2; k <= 5; k++) begin
            wait_frame();
            repeat (2) @(negedge PCLK);
            n_vec++; if (pw(0) !== 32'(75000 + 1000*k)) begin n_err++; $display("FAIL ramp_f%0d: got %0d exp %0d", k, pw(0), 75000 + 1000*k); end
        end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_hold: got %b exp 1", busy); end
        @(negedge PCLK);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_drop: got %b exp 0", busy); end
    endtask

    task automatic test_clamp();
        logic [31:0] d; logic e;
        int exp1 [4] = '{82000, 89000, 96000, 100000};
        int exp2 [4] = '{68000, 61000, 54000, 50000};
        apb_write(32'h04, 32'd7000, e);
        apb_write(32'h24, 32'd120000, e);
        apb_read(32'h24, d, e);
        n_vec++; if (d !== 32'd100000) begin n_err++; $display("FAIL clamp_hi: got %0d exp 100000", d); end
        apb_write(32'h28, 32'd0, e);
        apb_read(32'h28, d, e);
        n_vec++; if (d !== 32'd50000) begin n_err++; $display("FAIL clamp_lo: got %0d exp 50000", d); end
        for (int k = 0; k < 4; k++) begin
            wait_frame();
            repeat (4) @(negedge PCLK);
            n_vec++; if (pw(1) !== 32'(exp1[k])) begin n_err++; $display("FAIL clamp_ch1_f%0d: got %0d exp %0d", k+1, pw(1), exp1[k]); end
            n_vec++; if (pw(2) !== 32'(exp2[k])) begin n_err++; $display("FAIL clamp_ch2_f%0d: got %0d exp %0d", k+1, pw(2), exp2[k]); end
        end
        n_vec++; if (pw(0) !== 32'd80000) begin n_err++; $display("FAIL clamp_ch0: got %0d exp 80000", pw(0)); end
        apb_read(32'h44, d, e);
        n_vec++; if (d !== 32'd100000) begin n_err++; $display("FAIL clamp_rd_active1: got %0d exp 100000", d); end
    endtask

    task automatic test_mid_pass_target();
        logic e;
        apb_write(32'h04, 32'd1000, e);
        apb_write(32'h20, 32'd82000, e);
        wait_frame();
        @(negedge PCLK);
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 32'h2C; apb_if.PWDATA = 32'd90000;
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        n_vec++; if (pw(0) !== 32'd81000) begin n_err++; $display("FAIL mid_ch0: got %0d exp 81000", pw(0)); end
        n_vec++; if (dbg_state !== ST_UPDATE) begin n_err++; $display("FAIL mid_state: got %0d exp UPDATE", dbg_state); end
        @(negedge PCLK);
        apb_idle();
        @(negedge PCLK);
        n_vec++; if (pw(3) !== 32'd75000) begin n_err++; $display("FAIL mid_ch3_early: got %0d exp 75000", pw(3)); end
        @(negedge PCLK);
        n_vec++; if (pw(3) !== 32'd76000) begin n_err++; $display("FAIL mid_ch3: got %0d exp 76000", pw(3)); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_end_state: got %0d exp IDLE", dbg_state); end
    endtask

    task automatic test_snap();
        logic [31:0] d; logic e;
        apb_write(32'h20, 32'd60000, e);
        wait_frame();
        apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b1;
        apb_if.PADDR = 32'h00; apb_if.PWDATA = 32'h3;
        @(negedge PCLK);
        apb_if.PENABLE = 1'b1;
        @(negedge PCLK);
        apb_idle();
        n_vec++; if (pw(0) !== 32'd60000) begin n_err++; $display("FAIL snap_ch0: got %0d exp 60000", pw(0)); end
        n_vec++; if (pw(3) !== 32'd90000) begin n_err++; $display("FAIL snap_ch3: got %0d exp 90000", pw(3)); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL snap_state: got %0d exp IDLE", dbg_state); end
        @(negedge PCLK);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL snap_busy: got %b exp 0", busy); end
        apb_read(32'h00, d, e);
        n_vec++; if (d !== 32'h1 || e !== 1'b0) begin n_err++; $display("FAIL snap_ctrl_rd: got %h err %b exp 1 err 0", d, e); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e;
        apb_write(32'h08, 32'hFFFF_FFFF, e);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wr_status: got %b exp 1", e); end
        apb_read(32'hA0, d, e);
        n_vec++; if (e !== 1'b1 || d !== 32'd0) begin n_err++; $display("FAIL err_rd_40: got err %b data %h exp err 1 data 0", e, d); end
        apb_write(32'h40, 32'd12345, e);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wr_active: got %b exp 1", e); end
        apb_read(32'h40, d, e);
        n_vec++; if (d !== 32'd60000 || e !== 1'b0) begin n_err++; $display("FAIL err_active_kept: got %0d err %b exp 60000 err 0", d, e); end
        apb_read(32'h08, d, e);
        n_vec++; if (d !== 32'd0 || e !== 1'b0) begin n_err++; $display("FAIL err_status: got %h err %b exp 0 err 0", d, e); end
        apb_read(32'h2C, d, e);
        n_vec++; if (d !== 32'd90000) begin n_err++; $display("FAIL err_target3: got %0d exp 90000", d); end
        apb_write(32'h04, 32'd0, e);
        apb_read(32'h04, d, e);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL step_zero: got %0d exp 1", d); end
    endtask

    task automatic test_reset_mid_pass();
        logic [31:0] d; logic e;
        apb_write(32'h24, 32'd90000, e);
        wait_frame();
        @(negedge PCLK);
        n_vec++; if (dbg_state !== ST_UPDATE) begin n_err++; $display("FAIL rst_pre_state: got %0d exp UPDATE", dbg_state); end
        #2 PRESERN = 1'b0;
        #1;
        n_vec++; if (pulse_width !== {NUM_CH{32'd75000}}) begin n_err++; $display("FAIL rst_async_pw: got %h exp all 75000", pulse_width); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_async_state: got %0d exp IDLE", dbg_state); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b exp 0", busy); end
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_read(32'h04, d, e);
        n_vec++; if (d !== 32'd500) begin n_err++; $display("FAIL rst_step: got %0d exp 500", d); end
        apb_read(32'h24, d, e);
        n_vec++; if (d !== 32'd75000) begin n_err++; $display("FAIL rst_target1: got %0d exp 75000", d); end
        apb_read(32'h00, d, e);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_ctrl: got %h exp 0", d); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramp();
        test_clamp();
        test_mid_pass_target();
        test_snap();
        test_errors();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
